// File: rtl/fir_sample_fifo.sv
// Single-clock sample FIFO for the FIR datapath: registered read, occupancy count,
// derived full/empty/almost_full flags and sticky overflow/underflow error flags.
module fir_sample_fifo #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_put,
  input  logic [DATA_W-1:0] data_in,
  input  logic              en_get,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W + 1)'(AFULL_LVL);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   count_next;
  logic [DATA_W-1:0] data_out_reg;
  logic              overflow_reg;
  logic              underflow_reg;

  logic put_ok;
  logic get_ok;
  logic overflow_set;
  logic underflow_set;

  // A get at full frees the slot being written, so the put may proceed.
  assign get_ok        = en_get & ~empty;
  assign put_ok        = en_put & (~full | get_ok);
  assign overflow_set  = en_put & full & ~get_ok;
  assign underflow_set = en_get & empty;

  always_comb begin
    count_next = count_reg;
    case ({put_ok, get_ok})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // Storage is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (put_ok) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      data_out_reg  <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (put_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (get_ok) begin
        data_out_reg <= mem[rd_ptr_reg];
        rd_ptr_reg   <= rd_ptr_reg + PTR_ONE;
      end
      // A fresh error event takes priority over a clear in the same cycle.
      if (overflow_set) begin
        overflow_reg <= 1'b1;
      end else if (clr_err) begin
        overflow_reg <= 1'b0;
      end
      if (underflow_set) begin
        underflow_reg <= 1'b1;
      end else if (clr_err) begin
        underflow_reg <= 1'b0;
      end
    end
  end

  assign data_out    = data_out_reg;
  assign count       = count_reg;
  assign full        = (count_reg == DEPTH_CNT);
  assign empty       = (count_reg == '0);
  assign almost_full = (count_reg >= AFULL_CNT);
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;

endmodule

// File: tb/tb_fir_sample_fifo.sv
// Directed bench for fir_sample_fifo: reset, fill/drain, overflow, full and
// empty corner accesses, pointer wrap and asynchronous mid-stream reset.
module tb_fir_sample_fifo;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en_put;
  logic [DATA_W-1:0] data_in;
  logic              en_get;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  logic              clr_err;

  int checks = 0;
  int errors = 0;

  fir_sample_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_LVL(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_put      (en_put),
    .data_in     (data_in),
    .en_get      (en_get),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_put  = 1'b0;
    en_get  = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    logic [15:0] q[$];
    logic [15:0] exp_word;

    rst_n = 1'b0;
    idle();
    data_in = '0;

    // 1: reset held with random enables
    for (int i = 0; i < 5; i++) begin
      en_put  = 1'($urandom_range(0, 1));
      en_get  = 1'($urandom_range(0, 1));
      data_in = 16'($urandom);
      tick();
    end
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_afull", 32'(almost_full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    idle();
    rst_n = 1'b1;
    tick();

    // 2: fill 0x0001..0x0010, then drain in order
    for (int i = 1; i <= 16; i++) begin
      en_put  = 1'b1;
      data_in = 16'(i);
      tick();
      $display("put 0x%04h count=%0d full=%0b afull=%0b", data_in, count, full, almost_full);
      check("fill_count", 32'(count), 32'(i));
      check("fill_afull", 32'(almost_full), (i >= 12) ? 32'd1 : 32'd0);
      check("fill_full", 32'(full), (i == 16) ? 32'd1 : 32'd0);
    end
    idle();
    for (int i = 1; i <= 16; i++) begin
      en_get = 1'b1;
      tick();
      $display("get data_out=0x%04h count=%0d", data_out, count);
      check("drain_data", 32'(data_out), 32'(i));
      check("drain_count", 32'(count), 32'(16 - i));
    end
    idle();
    tick();
    check("drain_empty", 32'(empty), 32'd1);
    check("hold_data_out", 32'(data_out), 32'h0010);
    check("drain_no_uflow", 32'(underflow), 32'd0);

    // 3: overflow at full
    for (int i = 1; i <= 16; i++) begin
      en_put  = 1'b1;
      data_in = 16'(16'h0100 + i);
      tick();
    end
    data_in = 16'hBEEF;
    tick();
    $display("put 0xBEEF at full count=%0d overflow=%0b", count, overflow);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_no_uflow", 32'(underflow), 32'd0);
    en_put  = 1'b0;
    clr_err = 1'b1;
    tick();
    check("ovf_cleared", 32'(overflow), 32'd0);
    en_put = 1'b1;
    tick();
    check("ovf_set_wins_clr", 32'(overflow), 32'd1);
    en_put = 1'b0;
    tick();
    check("ovf_cleared2", 32'(overflow), 32'd0);
    idle();

    // 4: simultaneous put/get at full
    en_put  = 1'b1;
    en_get  = 1'b1;
    data_in = 16'h00AA;
    tick();
    $display("put 0x00AA + get at full data_out=0x%04h count=%0d", data_out, count);
    check("sim_count", 32'(count), 32'd16);
    check("sim_full", 32'(full), 32'd1);
    check("sim_oldest", 32'(data_out), 32'h0101);
    check("sim_no_ovf", 32'(overflow), 32'd0);
    idle();
    for (int i = 2; i <= 17; i++) begin
      en_get = 1'b1;
      tick();
      exp_word = (i == 17) ? 16'h00AA : 16'(16'h0100 + i);
      $display("get data_out=0x%04h", data_out);
      check("sim_drain", 32'(data_out), 32'(exp_word));
    end
    idle();
    tick();
    check("sim_empty", 32'(empty), 32'd1);

    // 5: underflow with simultaneous put at empty
    en_get  = 1'b1;
    en_put  = 1'b1;
    data_in = 16'h1234;
    tick();
    $display("get + put 0x1234 at empty underflow=%0b count=%0d", underflow, count);
    check("uf_flag", 32'(underflow), 32'd1);
    check("uf_count", 32'(count), 32'd1);
    check("uf_data_hold", 32'(data_out), 32'h00AA);
    en_put = 1'b0;
    tick();
    check("uf_next_get", 32'(data_out), 32'h1234);
    check("uf_count0", 32'(count), 32'd0);
    idle();

    // 6: wrap with three words in flight, then async reset mid-cycle
    for (int i = 0; i < 3; i++) begin
      en_put  = 1'b1;
      data_in = 16'(16'h2000 + i);
      q.push_back(data_in);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      en_put  = 1'b1;
      en_get  = 1'b1;
      data_in = 16'(16'h3000 + i);
      exp_word = q.pop_front();
      q.push_back(data_in);
      tick();
      $display("wrap put 0x%04h get data_out=0x%04h count=%0d", data_in, data_out, count);
      check("wrap_data", 32'(data_out), 32'(exp_word));
      check("wrap_count", 32'(count), 32'd3);
    end
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset count=%0d empty=%0b data_out=0x%04h", count, empty, data_out);
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_data_out", 32'(data_out), 32'd0);
    check("arst_underflow", 32'(underflow), 32'd0);
    tick();
    rst_n  = 1'b1;
    en_get = 1'b1;
    tick();
    check("post_rst_uflow", 32'(underflow), 32'd1);
    check("post_rst_count", 32'(count), 32'd0);
    check("post_rst_data", 32'(data_out), 32'd0);
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
